pipe_stage_skid: RTL



---
 rtl/pipe_stage_skid.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//   Decode/execute pipeline boundary with a valid/ready handshake and a
//   2-entry skid buffer. in_ready comes straight from the state register, so
//   there is no combinational path from out_ready back to in_ready. The stage
//   still sustains one beat per cycle.
//
//   Beyond the register boundary the stage provides:
//     - a synchronous flush that kills both buffered entries,
//     - a registered delay-slot flag that is fed back to decode,
//     - a saturating counter of downstream stall cycles for performance debug.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          synchronous active-high reset; overrides flush and handshake
//   flush        synchronous kill of all buffered entries
//   in_valid     upstream beat valid
//   in_ready     stage can accept a beat (registered state only)
//   in_data      upstream payload (opaque, passed through untouched)
//   in_ds_next   next instruction is in a delay slot
//   out_valid    head entry valid
//   out_ready    downstream accepts the head
//   out_data     head payload; NOP_VALUE whenever out_valid is 0
//   ds_o         registered delay-slot flag
//   occupancy    number of entries held (0..2)
//   stall_cnt    cycles with out_valid=1 and out_ready=0, saturating
//
// State table
//   state | meaning
//   EMPTY | no entry held; main holds NOP_VALUE
//   ONE   | head entry in main; skid unused
//   TWO   | head in main, younger entry in skid; upstream is held off
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int                   PAYLOAD_W = 120,
    parameter logic [PAYLOAD_W-1:0] NOP_VALUE = {PAYLOAD_W{1'b0}},
    parameter int                   CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    input  logic                 in_ds_next,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 ds_o,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;
    logic                 ds_q, ds_d;
    logic [CNT_W-1:0]     stall_q;

    logic in_fire;
    logic out_fire;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // main is reloaded with NOP_VALUE on every path into EMPTY, so the
    // head register can drive out_data directly without a mux.
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign ds_o      = ds_q;
    assign stall_cnt = stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
            ds_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ds_q    <= ds_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        ds_d    = ds_q;

        if (flush) begin
            // Beats firing in the same cycle are dropped along with the
            // buffered ones.
            state_d = EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
            ds_d    = 1'b0;
        end else begin
            if (in_fire) begin
                ds_d = in_ds_next;
            end

            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = NOP_VALUE;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                    ds_d    = 1'b0;
                end
            endcase
        end
    end

    // The stall counter is cleared only by reset. A flush cycle still counts
    // when the head is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

endmodule
